// File: rtl/msg_scroller_pkg.sv
// Shared constants and state encoding for the message scroller.
package msg_pkg;

  localparam int ADR_W = 5;
  // Window index width: one bit wider than the ROM address so pos+i never truncates.
  localparam int IDX_W = ADR_W + 1;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t FETCH  = 2'd1;
  localparam state_t SCROLL = 2'd2;

endpackage

// File: rtl/msg_scroller_scroll_timer.sv
// Enable-gated divide-by-DIV counter; emits a one-tick step pulse at terminal count.
module scroll_timer #(
  parameter int DIV = 8
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic enable,
  input  logic clr,
  output logic step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign step = enable && !clr && (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || step) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msg_scroller.sv
// Loads a message from the ROM sequencer into a buffer, then scrolls a DIGITS-wide window
// across it. Define MSG_SCROLLER_GAP_EN to insert a DIGITS-wide blank gap between repeats.
module msg_scroller
  import msg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 32,
  parameter int DIGITS     = 4,
  parameter int SCROLL_DIV = 8
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADR_W-1:0]         msg_len,
  input  logic [DATA_W-1:0]        rom_data,
  input  logic                     rom_done,
  output logic                     read_ROM,
  output logic [ADR_W-1:0]         adr_limit,
  output logic [DIGITS*DATA_W-1:0] disp,
  output logic                     busy,
  output logic                     loaded,
  output logic                     err
);

  localparam logic [DATA_W-1:0]        BLANK     = DATA_W'(BLANK_CHAR);
  localparam logic [DIGITS*DATA_W-1:0] BLANK_ALL = {DIGITS{BLANK}};

  state_t                   state_q, state_d;
  logic [ADR_W-1:0]         len_q, len_d;
  logic [ADR_W-1:0]         adr_q, adr_d;
  logic [ADR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic                     rd_q, rd_d;
  logic                     fill_q, fill_d;
  logic                     err_q, err_d;
  logic [IDX_W-1:0]         pos_q, pos_d;
  logic [DIGITS*DATA_W-1:0] disp_q, disp_d;
  logic [IDX_W-1:0]         period;
  logic [DIGITS*DATA_W-1:0] win;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     do_load, wr_en, timer_clr, step;

  assign do_load   = enable && start && !stop && (state_q == IDLE || state_q == SCROLL);
  assign timer_clr = (state_q != SCROLL) || (enable && (start || stop));

`ifdef MSG_SCROLLER_GAP_EN
  assign period = IDX_W'(len_q) + IDX_W'(DIGITS + 1);
`else
  assign period = IDX_W'(len_q) + IDX_W'(1);
`endif

  scroll_timer #(
    .DIV (SCROLL_DIV)
  ) u_timer (
    .CLK     (CLK),
    .reset_n (reset_n),
    .enable  (enable),
    .clr     (timer_clr),
    .step    (step)
  );

  // Indices past the message end only occur with the gap enabled; they read as blanks.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_win
    logic [IDX_W-1:0] idx;
    assign idx = (pos_q + IDX_W'(gi)) % period;
    assign win[(DIGITS-gi)*DATA_W-1 -: DATA_W] =
      (idx > IDX_W'(len_q)) ? BLANK : mem[idx[ADR_W-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    adr_d    = adr_q;
    rd_d     = rd_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    err_d    = err_q;
    pos_d    = pos_q;
    wr_en    = 1'b0;
    if (do_load) begin
      state_d  = FETCH;
      len_d    = msg_len;
      adr_d    = msg_len;
      rd_d     = 1'b1;
      wr_ptr_d = '0;
      fill_d   = 1'b1;
      err_d    = 1'b0;
    end else if (enable) begin
      case (state_q)
        FETCH: begin
          if (stop) begin
            state_d = IDLE;
            rd_d    = 1'b0;
          end else if (fill_q) begin
            fill_d = 1'b0;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == len_q) begin
              state_d = SCROLL;
              rd_d    = 1'b0;
              pos_d   = '0;
              err_d   = !rom_done;
            end
          end
        end
        SCROLL: begin
          if (stop) begin
            state_d = IDLE;
          end else if (step) begin
            pos_d = (pos_q == period - 1'b1) ? '0 : pos_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    disp_d = (state_q == SCROLL && !(enable && stop)) ? win : BLANK_ALL;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      adr_q    <= '0;
      wr_ptr_q <= '0;
      rd_q     <= 1'b0;
      fill_q   <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= '0;
      disp_q   <= BLANK_ALL;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      adr_q    <= adr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_q     <= rd_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
      disp_q   <= disp_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= rom_data;
    end
  end

  assign read_ROM  = rd_q;
  assign adr_limit = adr_q;
  assign disp      = disp_q;
  assign busy      = (state_q == FETCH);
  assign loaded    = (state_q == SCROLL);
  assign err       = err_q;

endmodule
